// File: rtl/mult_seq_pkg.sv
// mult_seq_pkg: shared constants, state encoding and pass schedule for the sequential multiplier
// Contents:
//   CORE_W     operand width of the shared combinational core
//   NUM_PASS   partial products per transaction
//   PASS_W     width of the pass counter
//   state_e    controller states, mirrored as ST_* vector constants
//   pass_cfg_t per-pass nibble selects and shift (in units of CORE_W)
//   PASS_TBL   schedule indexed by pass number
package mult_seq_pkg;

    localparam int CORE_W   = 4;
    localparam int NUM_PASS = 4;
    localparam int PASS_W   = $clog2(NUM_PASS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_RUN  = RUN;
    localparam logic [1:0] ST_DONE = DONE;

    // x_hi/y_hi pick the upper operand half; shift_n is the left shift in CORE_W steps
    typedef struct packed {
        logic       x_hi;
        logic       y_hi;
        logic [1:0] shift_n;
    } pass_cfg_t;

    // Entry [0] is the first pass: lo*lo, hi*lo, lo*hi, hi*hi
    localparam pass_cfg_t [NUM_PASS-1:0] PASS_TBL = {
        pass_cfg_t'{x_hi: 1'b1, y_hi: 1'b1, shift_n: 2'd2},
        pass_cfg_t'{x_hi: 1'b0, y_hi: 1'b1, shift_n: 2'd1},
        pass_cfg_t'{x_hi: 1'b1, y_hi: 1'b0, shift_n: 2'd1},
        pass_cfg_t'{x_hi: 1'b0, y_hi: 1'b0, shift_n: 2'd0}
    };

endpackage

// File: rtl/mult_seq_opsel.sv
// mult_seq_opsel: maps the pass number to core operands and accumulator shift
// Ports:
//   i_en     high while a transaction is running; low forces core operands to 0
//   i_pass   current pass number
//   i_a/i_b  registered transaction operands
//   o_x/o_y  operand halves for the shared core
//   o_shift  left shift applied to the core product for this pass
module mult_seq_opsel #(
    parameter int CORE_W  = mult_seq_pkg::CORE_W,
    parameter int IN_W    = 2*CORE_W,
    parameter int SHIFT_W = $clog2(IN_W) + 1
) (
    input  logic                            i_en,
    input  logic [mult_seq_pkg::PASS_W-1:0] i_pass,
    input  logic [IN_W-1:0]                 i_a,
    input  logic [IN_W-1:0]                 i_b,
    output logic [CORE_W-1:0]               o_x,
    output logic [CORE_W-1:0]               o_y,
    output logic [SHIFT_W-1:0]              o_shift
);

    import mult_seq_pkg::*;

    pass_cfg_t w_cfg;

    always_comb begin
        w_cfg   = PASS_TBL[i_pass];
        // Idle operands keep the shared core quiet outside RUN
        o_x     = !i_en ? '0 : w_cfg.x_hi ? i_a[IN_W-1 -: CORE_W] : i_a[CORE_W-1:0];
        o_y     = !i_en ? '0 : w_cfg.y_hi ? i_b[IN_W-1 -: CORE_W] : i_b[CORE_W-1:0];
        o_shift = SHIFT_W'(int'(w_cfg.shift_n) * CORE_W);
    end

endmodule

// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: valid/ready sequencer building an IN_W x IN_W product from a shared CORE_W x CORE_W core
// Ports:
//   clk, rst_n              clock and asynchronous active-low reset
//   i_in_valid/o_in_ready   request handshake, operands i_in_a, i_in_b
//   o_out_valid/i_out_ready result handshake, product o_out_p
//   o_core_x/o_core_y       operands to the external combinational core
//   i_core_o                core product, o_core_x * o_core_y in the same cycle
module mult_seq_ctrl #(
    parameter int CORE_W = mult_seq_pkg::CORE_W,
    parameter int IN_W   = 2*CORE_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_in_valid,
    output logic                o_in_ready,
    input  logic [IN_W-1:0]     i_in_a,
    input  logic [IN_W-1:0]     i_in_b,
    output logic                o_out_valid,
    input  logic                i_out_ready,
    output logic [2*IN_W-1:0]   o_out_p,
    output logic [CORE_W-1:0]   o_core_x,
    output logic [CORE_W-1:0]   o_core_y,
    input  logic [2*CORE_W-1:0] i_core_o
);

    import mult_seq_pkg::*;

    localparam int                SHIFT_W   = $clog2(IN_W) + 1;
    localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(NUM_PASS - 1);

    if (IN_W != 2*CORE_W) begin : g_bad_width
        $error("mult_seq_ctrl: IN_W must equal 2*CORE_W");
    end

    logic [1:0]          r_state;
    logic [PASS_W-1:0]   r_pass;
    logic [IN_W-1:0]     r_a;
    logic [IN_W-1:0]     r_b;
    logic [2*IN_W-1:0]   r_acc;
    logic [2*IN_W-1:0]   r_out_p;
    logic [SHIFT_W-1:0]  w_shift;
    logic [2*IN_W-1:0]   w_acc_nxt;
    logic                w_run;
    logic                w_accept;
    logic                w_last;
    logic                w_bad_state;

    assign o_in_ready  = (r_state == ST_IDLE);
    assign o_out_valid = (r_state == ST_DONE);
    assign o_out_p     = r_out_p;
    assign w_run       = (r_state == ST_RUN);
    assign w_accept    = i_in_valid && o_in_ready;
    assign w_last      = (r_pass == LAST_PASS);
    assign w_bad_state = !(o_in_ready || w_run || o_out_valid);

    mult_seq_opsel #(
        .CORE_W  (CORE_W),
        .IN_W    (IN_W),
        .SHIFT_W (SHIFT_W)
    ) u_opsel (
        .i_en    (w_run),
        .i_pass  (r_pass),
        .i_a     (r_a),
        .i_b     (r_b),
        .o_x     (o_core_x),
        .o_y     (o_core_y),
        .o_shift (w_shift)
    );

    // The widened partial product never overflows the accumulator, so the carry-out is simply dropped
    assign w_acc_nxt = r_acc + ((2*IN_W)'(i_core_o) << w_shift);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_pass  <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_out_p <= '0;
        end else begin
            if (w_accept) begin
                r_a     <= i_in_a;
                r_b     <= i_in_b;
                r_acc   <= '0;
                r_pass  <= '0;
                r_state <= ST_RUN;
            end
            if (w_run) begin
                r_acc  <= w_acc_nxt;
                r_pass <= r_pass + 1'b1;
                if (w_last) begin
                    r_out_p <= w_acc_nxt;
                    r_state <= ST_DONE;
                end
            end
            if ((o_out_valid && i_out_ready) || w_bad_state) begin
                r_state <= ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// tb_mult_seq_ctrl: directed and randomised checks of the sequential multiplier controller
module tb_mult_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_a = '0;
    logic [7:0]  in_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_p;
    logic [3:0]  core_x;
    logic [3:0]  core_y;
    logic [7:0]  core_o;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
    } vec_t;

    vec_t       vecs[9];
    logic [7:0] exp_core[4] = '{8'h24, 8'h14, 8'h23, 8'h13};

    always #5 clk = ~clk;

    assign core_o = core_x * core_y;

    mult_seq_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_in_a      (in_a),
        .i_in_b      (in_b),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_p     (out_p),
        .o_core_x    (core_x),
        .o_core_y    (core_y),
        .i_core_o    (core_o)
    );

    always @(negedge clk) begin
        if (rst_n && in_ready && out_valid) begin
            n_fail++;
            $display("FAIL mutex: in_ready=1 and out_valid=1 together at %0t", $time);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Called at the negedge where the request is presented; returns handshake-to-out_valid edges
    task automatic wait_out(input bit keep, input logic [7:0] na, input logic [7:0] nb, output int lat);
        int k;
        k = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            k++;
            in_valid = keep;
            in_a     = na;
            in_b     = nb;
            if (out_valid) break;
        end
        if (!out_valid) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_out: out_valid not seen within 20 cycles, got 0 expected 1");
        end
        lat = k - 1;
    endtask

    task automatic run_txn(input string nm, input logic [7:0] a, input logic [7:0] b, input logic [15:0] p);
        int lat;
        chk({nm, "_ready"}, in_ready, 1);
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        out_ready = 1'b1;
        wait_out(1'b0, 8'h00, 8'h00, lat);
        chk({nm, "_lat"}, lat, 4);
        chk({nm, "_p"}, out_p, p);
        @(negedge clk);
        chk({nm, "_idle"}, {in_ready, out_valid}, 2'b10);
    endtask

    initial begin
        int          lat;
        int          lo;
        bit          ok;
        logic [7:0]  ra;
        logic [7:0]  rb;
        logic [15:0] rp;

        vecs[0] = '{a: 8'hFF, b: 8'hFF, p: 16'hFE01};
        vecs[1] = '{a: 8'h00, b: 8'hA5, p: 16'h0000};
        vecs[2] = '{a: 8'h80, b: 8'h02, p: 16'h0100};
        vecs[3] = '{a: 8'h01, b: 8'h01, p: 16'h0001};
        vecs[4] = '{a: 8'h10, b: 8'h10, p: 16'h0100};
        vecs[5] = '{a: 8'h0F, b: 8'hF0, p: 16'h0E10};
        vecs[6] = '{a: 8'hFF, b: 8'h01, p: 16'h00FF};
        vecs[7] = '{a: 8'h7F, b: 8'h80, p: 16'h3F80};
        vecs[8] = '{a: 8'hAB, b: 8'hCD, p: 16'h88EF};

        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_p", out_p, 16'h0000);
        chk("rst_core", {core_x, core_y}, 8'h00);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1);

        // First transaction: pass-by-pass core operands, latency and busy window
        in_valid  = 1'b1;
        in_a      = 8'h12;
        in_b      = 8'h34;
        out_ready = 1'b1;
        lat = 0;
        lo  = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (i <= 4) chk($sformatf("core_pass%0d", i - 1), {core_x, core_y}, exp_core[i-1]);
            if (i == 5) chk("core_done", {core_x, core_y}, 8'h00);
            if (out_valid && lat == 0) begin
                lat = i - 1;
                chk("p_12x34", out_p, 16'h03A8);
            end
            if (in_ready) break;
            lo++;
        end
        chk("lat_12x34", lat, 4);
        chk("busy_cycles", lo, 5);
        chk("core_idle", {core_x, core_y}, 8'h00);

        for (int i = 0; i < 9; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].p);
        end

        // Backpressure with a request already waiting behind the result
        in_valid  = 1'b1;
        in_a      = 8'h12;
        in_b      = 8'h34;
        out_ready = 1'b0;
        wait_out(1'b1, 8'h03, 8'h05, lat);
        chk("bp_lat", lat, 4);
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!(out_valid && out_p == 16'h03A8 && !in_ready)) ok = 1'b0;
        end
        chk("bp_hold", ok, 1);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release", {in_ready, out_valid}, 2'b10);

        // Waiting request is taken now; keep in_valid high for the next one
        wait_out(1'b1, 8'hF0, 8'h0F, lat);
        chk("b2b0_lat", lat, 4);
        chk("b2b0_p", out_p, 16'h000F);
        @(negedge clk);
        chk("b2b_gap", {in_ready, out_valid}, 2'b10);
        wait_out(1'b0, 8'h00, 8'h00, lat);
        chk("b2b1_lat", lat, 4);
        chk("b2b1_p", out_p, 16'h0E10);
        @(negedge clk);

        // Reset during pass 2
        in_valid = 1'b1;
        in_a     = 8'hAB;
        in_b     = 8'hCD;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        chk("midrst_state", {out_valid, out_p}, 17'h0);
        chk("midrst_core", {core_x, core_y}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid || !in_ready) ok = 1'b0;
        end
        chk("midrst_quiet", ok, 1);
        run_txn("after_rst", 8'hAB, 8'hCD, 16'h88EF);

        // Random operands, random idle gaps and output stalls
        for (int n = 0; n < 1000; n++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rp = 16'(ra) * 16'(rb);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            in_valid  = 1'b1;
            in_a      = ra;
            in_b      = rb;
            out_ready = 1'b0;
            wait_out(1'b0, 8'h00, 8'h00, lat);
            chk("rnd_lat", lat, 4);
            chk($sformatf("rnd_p_%02h_%02h", ra, rb), out_p, rp);
            ok = 1'b1;
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                if (!out_valid || out_p !== rp) ok = 1'b0;
            end
            chk("rnd_hold", ok, 1);
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            if (!in_ready) chk("rnd_ready", in_ready, 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
